// File: rtl/heap_pkg.sv
// Shared definitions for the top-K min-heap front end.
// Holds default widths, the key helpers and the controller state encoding.
package heap_pkg;

  localparam int DATA_W     = 32;
  localparam int KEY_W      = 16;
  localparam int LEVELS_DEF = 5;
  localparam logic [DATA_W-1:0] INIT_DATA_DEF = '0;

  typedef logic [DATA_W-1:0] item_t;
  typedef logic [KEY_W-1:0]  key_t;

  typedef enum logic [2:0] {
    ST_UNINIT,
    ST_INIT_PULSE,
    ST_INIT_WAIT,
    ST_RUN,
    ST_WAIT_ROOT,
    ST_DRAIN
  } state_t;

  function automatic key_t key_of(input item_t item);
    return item[KEY_W-1:0];
  endfunction

  // Unsigned compare; ties are not "greater", so equal keys are dropped.
  function automatic logic key_gt(input key_t a, input key_t b);
    return a > b;
  endfunction

endpackage

// File: rtl/heap_cnt_sat.sv
// Saturating up-counter with synchronous clear.
// Holds at all-ones instead of wrapping.
module heap_cnt_sat #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             inc,
  output logic [WIDTH-1:0] cnt
);

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      cnt <= '0;
    end else if (inc && (cnt != '1)) begin
      cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/heap_insert_ctrl.sv
// Front-end sequencer for the pipelined top-K min-heap: init, filter against
// the shadow root, replace-root issue into level 0, and frame drain.
//
// state       | meaning
// ------------+------------------------------------------------------------
// UNINIT      | after reset, heap contents undefined; waiting for init_req
// INIT_PULSE  | one-cycle heap_init to all levels; root and counters cleared
// INIT_WAIT   | waiting out the deepest level's init sweep
// RUN         | accepting candidates; drops one per cycle, inserts go out
// WAIT_ROOT   | replace-root issued; capturing level-0 root write-back
// DRAIN       | last item seen; waiting for the swap ripple, then done
module heap_insert_ctrl
  import heap_pkg::*;
#(
  parameter int DATA_WIDTH = DATA_W,
  parameter int KEY_WIDTH  = KEY_W,
  parameter int LEVELS     = LEVELS_DEF,
  parameter int ADDR_WIDTH = 5,
  parameter int CNT_WIDTH  = 16,
  parameter logic [DATA_WIDTH-1:0] INIT_DATA = '0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  init_req,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DATA_WIDTH-1:0] in_data,
  input  logic                  in_last,
  output logic                  heap_init,
  output logic                  heap_update,
  output logic [ADDR_WIDTH-1:0] heap_addr,
  output logic                  heap_branch,
  output logic [DATA_WIDTH-1:0] heap_data,
  input  logic                  root_we,
  input  logic [DATA_WIDTH-1:0] root_data,
  output logic [DATA_WIDTH-1:0] root,
  output logic [CNT_WIDTH-1:0]  acc_cnt,
  output logic [CNT_WIDTH-1:0]  drop_cnt,
  output logic                  busy,
  output logic                  done
);

  localparam int INIT_CYC  = (1 << (LEVELS - 1)) + 1;
  localparam int DRAIN_CYC = 2 * LEVELS + 2;
  localparam int TMR_MAX   = (INIT_CYC > DRAIN_CYC) ? INIT_CYC : DRAIN_CYC;
  localparam int TMR_W     = $clog2(TMR_MAX + 1);
  localparam logic [TMR_W-1:0] INIT_LOAD  = TMR_W'(INIT_CYC);
  localparam logic [TMR_W-1:0] DRAIN_LOAD = TMR_W'(DRAIN_CYC);

  state_t           state_q, state_nx;
  logic [TMR_W-1:0] tmr_q, tmr_nx;
  logic             pend_q, pend_nx;
  logic             last_q, last_nx;
  logic             acc_inc, drop_inc, upd_nx, done_nx;
  logic             hs, cand_gt, tmr_one, init_now;

  assign hs       = in_valid && in_ready;
  assign cand_gt  = key_gt(key_t'(in_data[KEY_WIDTH-1:0]), key_t'(root[KEY_WIDTH-1:0]));
  assign tmr_one  = (tmr_q == TMR_W'(1));
  assign init_now = pend_q || init_req;

  assign heap_addr   = '0;
  assign heap_branch = 1'b0;

  always_comb begin
    state_nx = state_q;
    tmr_nx   = tmr_q;
    pend_nx  = pend_q;
    last_nx  = last_q;
    acc_inc  = 1'b0;
    drop_inc = 1'b0;
    upd_nx   = 1'b0;
    done_nx  = 1'b0;
    case (state_q)
      ST_UNINIT: begin
        if (init_req) state_nx = ST_INIT_PULSE;
      end
      ST_INIT_PULSE: begin
        tmr_nx   = INIT_LOAD;
        state_nx = ST_INIT_WAIT;
      end
      ST_INIT_WAIT: begin
        tmr_nx = tmr_q - TMR_W'(1);
        if (tmr_one) state_nx = init_now ? ST_INIT_PULSE : ST_RUN;
      end
      ST_RUN: begin
        if (init_req) begin
          state_nx = ST_INIT_PULSE;
        end else if (hs) begin
          if (cand_gt) begin
            upd_nx   = 1'b1;
            acc_inc  = 1'b1;
            last_nx  = in_last;
            state_nx = ST_WAIT_ROOT;
          end else begin
            drop_inc = 1'b1;
            if (in_last) begin
              tmr_nx   = DRAIN_LOAD;
              state_nx = ST_DRAIN;
            end
          end
        end
      end
      ST_WAIT_ROOT: begin
        // Level 0 always writes the root back this cycle, so one cycle is enough.
        if (last_q) begin
          tmr_nx   = DRAIN_LOAD;
          state_nx = ST_DRAIN;
        end else begin
          state_nx = init_now ? ST_INIT_PULSE : ST_RUN;
        end
      end
      ST_DRAIN: begin
        tmr_nx = tmr_q - TMR_W'(1);
        if (tmr_one) begin
          done_nx  = 1'b1;
          state_nx = init_now ? ST_INIT_PULSE : ST_RUN;
        end
      end
      default: state_nx = ST_UNINIT;
    endcase
    if (init_req && (state_q inside {ST_INIT_WAIT, ST_WAIT_ROOT, ST_DRAIN})) pend_nx = 1'b1;
    if (state_nx == ST_INIT_PULSE) pend_nx = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_UNINIT;
      tmr_q       <= '0;
      pend_q      <= 1'b0;
      last_q      <= 1'b0;
      in_ready    <= 1'b0;
      busy        <= 1'b1;
      heap_init   <= 1'b0;
      heap_update <= 1'b0;
      heap_data   <= '0;
      root        <= INIT_DATA;
      done        <= 1'b0;
    end else begin
      state_q     <= state_nx;
      tmr_q       <= tmr_nx;
      pend_q      <= pend_nx;
      last_q      <= last_nx;
      in_ready    <= (state_nx == ST_RUN);
      busy        <= (state_nx != ST_RUN);
      heap_init   <= (state_nx == ST_INIT_PULSE);
      heap_update <= upd_nx;
      done        <= done_nx;
      if (upd_nx) heap_data <= in_data;
      if (state_q == ST_INIT_PULSE) begin
        root <= INIT_DATA;
      end else if (root_we) begin
        root <= root_data;
      end
    end
  end

  heap_cnt_sat #(.WIDTH(CNT_WIDTH)) u_acc_cnt (
    .clk (clk),
    .rst (rst),
    .clr (state_q == ST_INIT_PULSE),
    .inc (acc_inc),
    .cnt (acc_cnt)
  );

  heap_cnt_sat #(.WIDTH(CNT_WIDTH)) u_drop_cnt (
    .clk (clk),
    .rst (rst),
    .clr (state_q == ST_INIT_PULSE),
    .inc (drop_inc),
    .cnt (drop_cnt)
  );

endmodule
